btb_update_ctrl: RTL

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

---
 rtl/btb_pkg.sv | 22 ++
 rtl/btb_upd_fifo.sv | 61 ++++++
 rtl/btb_update_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// +--------------------------------------------------------------------+
// | btb_pkg : shared types for the BTB update controller               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package btb_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        br_en;
   } btb_upd_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } btb_state_t;

endpackage

`default_nettype wire

// File: rtl/btb_upd_fifo.sv
// +--------------------------------------------------------------------+
// | btb_upd_fifo : FIFO of pending BTB updates, synchronous clear      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module btb_upd_fifo
   import btb_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     clear_i,
   input  logic     push_i,
   input  btb_upd_t push_data_i,
   input  logic     pop_i,
   output logic     full_o,
   output logic     empty_o,
   output btb_upd_t head_o
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = $clog2(QDEPTH) + 1;

   btb_upd_t             mem_q [QDEPTH];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [CNT_W-1:0]     count_q;

   assign full_o  = (count_q == CNT_W'(QDEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_i)
         mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

`default_nettype wire

// File: rtl/btb_update_ctrl.sv
// +--------------------------------------------------------------------+
// | btb_update_ctrl : queues BTB corrections from EX, sweeps on flush  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module btb_update_ctrl
   import btb_pkg::*;
#(
   parameter int BTB_INDEX     = 4,
   parameter int BTB_IDX_START = 5,
   parameter int QDEPTH        = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        res_valid,
   input  logic [31:0] res_pc,
   input  logic [31:0] res_target,
   input  logic        res_taken,
   input  logic        res_pred_hit,
   input  logic [31:0] res_pred_pc,
   input  logic        flush_req,
   output logic        res_ready,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic        btb_load,
   output logic        btb_br_en,
   output logic [31:0] btb_pc_address_ex,
   output logic [31:0] btb_br_address,
   output logic        flush_busy,
   output logic [31:0] mispred_count
);

   localparam int                   IDX_LSB    = BTB_IDX_START - BTB_INDEX + 1;
   localparam logic [BTB_INDEX-1:0] SWEEP_LAST = '1;

   btb_state_t           state_q, state_d;
   logic [BTB_INDEX-1:0] sweep_cnt_q, sweep_cnt_d;
   logic [31:0]          mispred_count_q;

   logic     w_full, w_empty, w_push, w_pop, w_clear, w_xfer, w_upd;
   btb_upd_t w_head, w_push_data;
   logic [31:0] w_sweep_addr;

   assign w_upd = (res_taken && (!res_pred_hit || (res_pred_pc != res_target)))
               || (!res_taken && res_pred_hit);
   assign w_push_data  = '{pc: res_pc, target: (res_taken ? res_target : 32'h0), br_en: res_taken};
   assign w_sweep_addr = 32'(sweep_cnt_q) << IDX_LSB;
   assign mispred_count = mispred_count_q;

   btb_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (w_clear),
      .push_i      (w_push),
      .push_data_i (w_push_data),
      .pop_i       (w_pop),
      .full_o      (w_full),
      .empty_o     (w_empty),
      .head_o      (w_head)
   );

   always_comb begin
      state_d           = state_q;
      sweep_cnt_d       = sweep_cnt_q;
      res_ready         = 1'b0;
      w_xfer            = 1'b0;
      mispredict        = 1'b0;
      redirect_pc       = 32'h0;
      btb_load          = 1'b0;
      btb_br_en         = 1'b0;
      btb_pc_address_ex = 32'h0;
      btb_br_address    = 32'h0;
      flush_busy        = 1'b0;
      w_push            = 1'b0;
      w_pop             = 1'b0;
      w_clear           = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               res_ready = !w_full;
               w_xfer    = res_valid && res_ready;
               if (w_xfer && w_upd) begin
                  mispredict  = 1'b1;
                  redirect_pc = res_taken ? res_target : (res_pc + 32'd4);
                  // A coincident flush wipes the queue, so the entry is dropped.
                  w_push      = !flush_req;
               end
               if (!w_empty) begin
                  btb_load          = 1'b1;
                  btb_br_en         = w_head.br_en;
                  btb_pc_address_ex = w_head.pc;
                  btb_br_address    = w_head.target;
                  w_pop             = 1'b1;
               end
               if (flush_req) begin
                  state_d     = SWEEP;
                  sweep_cnt_d = '0;
                  w_clear     = 1'b1;
               end
            end
            SWEEP: begin
               btb_load          = 1'b1;
               btb_pc_address_ex = w_sweep_addr;
               flush_busy        = 1'b1;
               sweep_cnt_d       = sweep_cnt_q + 1'b1;
               if (sweep_cnt_q == SWEEP_LAST)
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         sweep_cnt_q     <= '0;
         mispred_count_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         sweep_cnt_q <= sweep_cnt_d;
         if (mispredict)
            mispred_count_q <= mispred_count_q + 32'd1;
      end
   end

endmodule

`default_nettype wire
